// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg: shared types and constants for the UART TX scheduler.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int               cand;
  logic [IDX_W-1:0] cidx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
//------------------------------------------------------------------------------
// uart_tx_scheduler: round-robin shared UART TX, 8N1 (8E1 when UART_TX_PARITY_EN).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              baud_tick,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [clog2_min1(NUM_REQ)-1:0]    grant_id,
  output logic                              busy,
  output logic                              tx
);

  localparam int               IDX_W      = clog2_min1(NUM_REQ);
  localparam int               CNT_W      = clog2_min1(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_REQ   = IDX_W'(NUM_REQ - 1);
  localparam logic [1:0]       STOP_LAST  = 2'(STOP_BITS - 1);
  localparam logic             MULTI_STOP = (STOP_BITS > 1);

  tx_state_t          state, next_state;
  logic [IDX_W-1:0]   rr_ptr, arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic               accept;
  logic [DATA_W-1:0]  sel_data, shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [1:0]         stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic               parity_bit;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // With a single stop bit the tick that begins it also ends the frame.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req_ready  = '0;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          accept     = 1'b1;
          req_ready  = arb_grant;
          next_state = ARMED;
        end
      end
      ARMED: if (baud_tick) next_state = START;
      START: if (baud_tick) next_state = DATA;
      DATA: begin
        if (baud_tick && bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = MULTI_STOP ? STOP : IDLE;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tick) next_state = MULTI_STOP ? STOP : IDLE;
`endif
      STOP: if (baud_tick && stop_cnt == STOP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= UART_IDLE_LEVEL;
      busy       <= 1'b0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      busy <= (next_state != IDLE);
      if (accept) begin
        shreg      <= sel_data;
        grant_id   <= arb_idx;
        rr_ptr     <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^sel_data;
`endif
      end
      // A tick seen in the accept cycle lands in IDLE and is ignored.
      if (baud_tick) begin
        case (state)
          ARMED: tx <= UART_START_LEVEL;
          START: begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx       <= parity_bit;
`else
              tx       <= UART_IDLE_LEVEL;
              stop_cnt <= 2'd1;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            tx       <= UART_IDLE_LEVEL;
            stop_cnt <= 2'd1;
          end
`endif
          STOP:    stop_cnt <= stop_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
//------------------------------------------------------------------------------
// tb_uart_tx_scheduler: directed bench with a bit-queue reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int BAUD_DIV = 32;
  localparam int MID      = BAUD_DIV / 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        baud_tick = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx;

  int         errors = 0;
  int         checks = 0;
  int         tcnt = 0;
  logic [3:0] rdy_q = '0;
  int         glog[$];
  bit         model_on = 1'b0;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // Baud strobe plus auto-drop of req_valid once the requester has been accepted.
  always @(posedge clk) begin
    #1;
    baud_tick = (tcnt == BAUD_DIV - 1);
    tcnt      = (tcnt == BAUD_DIV - 1) ? 0 : tcnt + 1;
    req_valid = req_valid & ~rdy_q;
    rdy_q     = '0;
  end

  always @(negedge clk) begin
    if (rst_n && req_ready != 4'b0) begin
      rdy_q = req_ready;
      for (int i = 0; i < NUM_REQ; i++) if (bit'(req_ready >> i)) glog.push_back(i);
    end
  end

  // Reference: a frame is a queue of line levels, one popped per tick after the accept cycle.
  logic m_tx = 1'b1;
  bit   m_busy = 1'b0;
  int   m_ptr = 0;
  int   m_gid = 0;
  bit   m_bits[$];

  always @(negedge clk) begin : model
    int         g;
    int         c;
    logic [3:0] exp_rdy;
    logic [7:0] d;
    if (!rst_n) begin
      m_tx = 1'b1; m_busy = 1'b0; m_ptr = 0; m_gid = 0;
      m_bits.delete();
      if (model_on) begin
        chk("rst_tx", 64'(tx), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
      end
    end else begin
      g = -1;
      exp_rdy = '0;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (g < 0 && bit'(req_valid >> c)) g = c;
        end
      end
      if (g >= 0) exp_rdy = 4'(1 << g);
      if (model_on) begin
        chk("model_tx", 64'(tx), 64'(m_tx));
        chk("model_busy", 64'(busy), 64'(m_busy));
        chk("model_ready", 64'(req_ready), 64'(exp_rdy));
        chk("model_gid", 64'(grant_id), 64'(m_gid));
      end
      if (g >= 0) begin
        m_gid = g;
        m_ptr = (g + 1) % NUM_REQ;
        m_busy = 1'b1;
        d = 8'(req_data >> (g * 8));
        m_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) m_bits.push_back(bit'(d >> i));
`ifdef UART_TX_PARITY_EN
        m_bits.push_back(^d);
`endif
        m_bits.push_back(1'b1);
      end else if (m_busy && baud_tick) begin
        m_tx = m_bits.pop_front();
        if (m_bits.size() == 0) m_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = '0;
    glog.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic to_mid();
    @(negedge clk);
    while (tcnt != MID) @(negedge clk);
  endtask

  // Mid-bit samples starting at the next start bit; bit k of bits is sample k.
  task automatic capture(input int n, output logic [63:0] bits, output logic [63:0] bsy);
    int guard;
    bits = '0; bsy = '0; guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (tx !== 1'b0 && guard < 4 * FRAME_BITS * BAUD_DIV);
    if (tx !== 1'b0) begin
      timeout("capture_start");
      return;
    end
    for (int k = 0; k < n; k++) begin
      do @(negedge clk); while (tcnt != MID);
      bits = bits | (64'(tx) << k);
      bsy  = bsy | (64'(busy) << k);
    end
  endtask

  task automatic wait_grants(input int n, input string name);
    int guard;
    guard = 0;
    while (glog.size() < n && guard < 8 * FRAME_BITS * BAUD_DIV) begin
      @(negedge clk);
      guard++;
    end
    if (glog.size() < n) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((busy || req_valid != 4'b0) && guard < 8 * FRAME_BITS * BAUD_DIV) begin
      @(negedge clk);
      guard++;
    end
    if (busy) timeout(name);
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    @(posedge clk); #2;
    req_data[idx*8 +: 8] = d;
    req_valid[idx] = 1'b1;
  endtask

  logic [63:0] bits, bsy;
  logic [10:0] t2_exp [4];
  logic [10:0] mask;

  initial begin
`ifdef UART_TX_PARITY_EN
    t2_exp = '{11'h540, 11'h742, 11'h744, 11'h546};
`else
    t2_exp = '{11'h340, 11'h342, 11'h344, 11'h346};
`endif
    mask = 11'((1 << FRAME_BITS) - 1);

    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(tx), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_gid", 64'(grant_id), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    model_on = 1'b1;

    // 1: single request, 0x55
    send(0, 8'h55);
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    chk("t1_ready_pulse", 64'(req_ready), 64'(0));
    chk("t1_gid", 64'(grant_id), 64'(0));
    chk("t1_busy", 64'(busy), 64'(1));
    capture(FRAME_BITS, bits, bsy);
`ifdef UART_TX_PARITY_EN
    chk("t1_frame", bits[10:0], 64'(11'h4AA));
`else
    chk("t1_frame", bits[9:0], 64'(10'h2AA));
`endif
    chk("t1_busy_last", 64'(bsy[FRAME_BITS-2]), 64'(1));
    chk("t1_busy_stop", 64'(bsy[FRAME_BITS-1]), 64'(0));
    wait_idle("t1_idle");

    // 2: four requesters at once, back-to-back frames
    do_reset();
    @(posedge clk); #2;
    req_data = 32'hA3A2A1A0;
    req_valid = 4'hF;
    capture(4 * FRAME_BITS, bits, bsy);
    for (int i = 0; i < 4; i++)
      chk("t2_frame", 64'(11'(bits >> (i * FRAME_BITS)) & mask), 64'(t2_exp[i]));
    chk("t2_ngrants", 64'(glog.size()), 64'(4));
    if (glog.size() >= 4) for (int i = 0; i < 4; i++) chk("t2_order", 64'(glog[i]), 64'(i));
    wait_idle("t2_idle");

    // 3: pointer after a req2 grant
    do_reset();
    send(2, 8'h12);
    wait_grants(1, "t3_first");
    send(1, 8'h11);
    req_data[31:24] = 8'h13;
    req_valid[3] = 1'b1;
    wait_grants(2, "t3_second");
    @(negedge clk);
    chk("t3_gid", 64'(grant_id), 64'(3));
    wait_grants(3, "t3_third");
    if (glog.size() >= 3) begin
      chk("t3_g0", 64'(glog[0]), 64'(2));
      chk("t3_g1", 64'(glog[1]), 64'(3));
      chk("t3_g2", 64'(glog[2]), 64'(1));
    end
    wait_idle("t3_idle");

    // 4: tick coincident with accept
    do_reset();
    for (int n = 0; n < 2 * BAUD_DIV; n++) begin
      @(posedge clk); #2;
      if (baud_tick) break;
    end
    req_data[7:0] = 8'h00;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t4_accept", 64'(req_ready), 64'(4'b0001));
    to_mid();
    chk("t4_hold_idle", 64'(tx), 64'(1));
    to_mid();
    chk("t4_start", 64'(tx), 64'(0));
    wait_idle("t4_idle");

    // 5: reset mid-DATA
    do_reset();
    send(1, 8'h5A);
    capture(4, bits, bsy);
    chk("t5_pre", bits[3:0], 64'(4'b0100));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_tx", 64'(tx), 64'(1));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_gid", 64'(grant_id), 64'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    glog.delete();
    send(0, 8'h30);
    req_data[31:24] = 8'h33;
    req_valid[3] = 1'b1;
    wait_grants(2, "t5_grants");
    if (glog.size() >= 2) begin
      chk("t5_g0", 64'(glog[0]), 64'(0));
      chk("t5_g1", 64'(glog[1]), 64'(3));
    end
    wait_idle("t5_idle");

    // 6: parity frames (plain 8N1 frame in the default build)
    do_reset();
    send(0, 8'h07);
    capture(FRAME_BITS, bits, bsy);
`ifdef UART_TX_PARITY_EN
    chk("t6_par1", bits[10:0], 64'(11'h60E));
    wait_idle("t6_idle1");
    send(0, 8'h03);
    capture(FRAME_BITS, bits, bsy);
    chk("t6_par0", bits[10:0], 64'(11'h406));
`else
    chk("t6_frame", bits[9:0], 64'(10'h20E));
`endif
    wait_idle("t6_idle");
    repeat (BAUD_DIV) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
